// File: rtl/prio_code_decoder.sv
// Rebuilds a decision vector from a stream of bit-index codes, one frame at a time.
// It also keeps a running count of distinct bits and a sticky error for bad or repeated indices.
//
// state | meaning
// IDLE  | waiting for the first code of a frame
// ACCUM | collecting codes into the accumulator
// HOLD  | presenting the completed vector to the consumer
module prio_code_decoder #(
  parameter int VEC_W = 36,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic [IDX_W:0]   out_cnt,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [VEC_W-1:0] acc, acc_nxt;
  logic [IDX_W:0]   cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             xfer;
  logic             in_range;
  logic             dup;
  logic [VEC_W-1:0] onehot;

  // Handshake flags decode straight from the state register, so reset reaches them with no clock.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign xfer      = in_valid & in_ready;

  assign in_range = ({1'b0, in_idx} < (IDX_W+1)'(VEC_W));
  assign onehot   = in_range ? (VEC_W'(1) << in_idx) : '0;
  assign dup      = |(acc & onehot);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (xfer) begin
          acc_nxt   = onehot;
          cnt_nxt   = {{IDX_W{1'b0}}, in_range};
          err_nxt   = ~in_range;
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_nxt = acc | onehot;
          if (in_range && !dup) cnt_nxt = cnt + (IDX_W+1)'(1);
          if (!in_range || dup) err_nxt = 1'b1;
          if (in_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Outputs are the registered accumulator; they stay unchanged in HOLD because no transfer can occur there.
  assign out_vec = acc;
  assign out_cnt = cnt;
  assign out_err = err;

endmodule

// File: tb/tb_prio_code_decoder.sv
// Directed bench for prio_code_decoder: a vector table for single frames,
// plus hand-written sequences for stall, mid-frame reset and back-to-back frames.
module tb_prio_code_decoder;

  localparam int VEC_W = 36;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_vec;
  logic [IDX_W:0]   out_cnt;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  prio_code_decoder #(.VEC_W(VEC_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_cnt(out_cnt), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             ordy;
    logic             ir;
    logic             ov;
    logic [VEC_W-1:0] vec;
    logic [IDX_W:0]   cnt;
    logic             err;
  } step_t;

  step_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ir, input logic ov,
                         input logic [VEC_W-1:0] vec, input logic [IDX_W:0] cnt, input logic err);
    chk({nm, ".in_ready"},  64'(in_ready),  64'(ir));
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({nm, ".out_vec"},   64'(out_vec),   64'(vec));
    chk({nm, ".out_cnt"},   64'(out_cnt),   64'(cnt));
    chk({nm, ".out_err"},   64'(out_err),   64'(err));
  endtask

  task automatic drive(input logic v, input logic [IDX_W-1:0] idx, input logic last, input logic ordy);
    in_valid  = v;
    in_idx    = idx;
    in_last   = last;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame with out_ready=1 throughout and in_valid left high afterwards,
  // checking the single HOLD cycle between frames against a bit-set model.
  task automatic send_frame(input string nm, input int codes[$]);
    logic [VEC_W-1:0] mvec;
    logic             merr;
    mvec = '0;
    merr = 1'b0;
    chk({nm, ".start_ready"}, 64'(in_ready), 64'(1));
    foreach (codes[i]) begin
      drive(1'b1, IDX_W'(codes[i]), (i == codes.size() - 1), 1'b1);
      if (codes[i] >= VEC_W || mvec[codes[i]]) merr = 1'b1;
      if (codes[i] < VEC_W) mvec[codes[i]] = 1'b1;
      tick();
    end
    chk_all({nm, ".hold"}, 1'b0, 1'b1, mvec, (IDX_W+1)'($countones(mvec)), merr);
    drive(1'b1, '0, 1'b0, 1'b1);
    tick();
    chk_all({nm, ".idle"}, 1'b1, 1'b0, mvec, (IDX_W+1)'($countones(mvec)), merr);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];

    // single-frame vectors: each row is inputs for one edge, then outputs expected just after it
    //            v     idx   last  ordy  ir    ov    vec              cnt  err
    tbl.push_back('{1'b1, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000001, 7'd1, 1'b0});
    tbl.push_back('{1'b1, 6'd5,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000021, 7'd2, 1'b0});
    tbl.push_back('{1'b1, 6'd35, 1'b1, 1'b1, 1'b0, 1'b1, 36'h800000021, 7'd3, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h800000021, 7'd3, 1'b0});
    tbl.push_back('{1'b1, 6'd7,  1'b1, 1'b0, 1'b0, 1'b1, 36'h000000080, 7'd1, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000080, 7'd1, 1'b0});
    tbl.push_back('{1'b1, 6'd3,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000008, 7'd1, 1'b0});
    tbl.push_back('{1'b0, 6'd9,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000008, 7'd1, 1'b0});
    tbl.push_back('{1'b1, 6'd3,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000008, 7'd1, 1'b1});
    tbl.push_back('{1'b1, 6'd40, 1'b1, 1'b1, 1'b0, 1'b1, 36'h000000008, 7'd1, 1'b1});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000008, 7'd1, 1'b1});
    tbl.push_back('{1'b1, 6'd1,  1'b1, 1'b0, 1'b0, 1'b1, 36'h000000002, 7'd1, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000002, 7'd1, 1'b0});
    tbl.push_back('{1'b1, 6'd35, 1'b0, 1'b1, 1'b1, 1'b0, 36'h800000000, 7'd1, 1'b0});
    tbl.push_back('{1'b1, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h800000001, 7'd2, 1'b0});
    tbl.push_back('{1'b1, 6'd5,  1'b1, 1'b1, 1'b0, 1'b1, 36'h800000021, 7'd3, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h800000021, 7'd3, 1'b0});
    tbl.push_back('{1'b1, 6'd36, 1'b0, 1'b1, 1'b1, 1'b0, 36'h000000000, 7'd0, 1'b1});
    tbl.push_back('{1'b1, 6'd35, 1'b1, 1'b1, 1'b0, 1'b1, 36'h800000000, 7'd1, 1'b1});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h800000000, 7'd1, 1'b1});
    tbl.push_back('{1'b1, 6'd63, 1'b1, 1'b1, 1'b0, 1'b1, 36'h000000000, 7'd0, 1'b1});
    tbl.push_back('{1'b0, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 36'h000000000, 7'd0, 1'b1});

    // asynchronous reset with a code offered: outputs clear before any clock edge
    rst_n = 1'b1;
    drive(1'b1, 6'd5, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("reset_async", 1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_all("after_reset", 1'b1, 1'b0, '0, '0, 1'b0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].idx, tbl[i].last, tbl[i].ordy);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].vec, tbl[i].cnt, tbl[i].err);
    end

    // consumer stall with a code waiting: nothing moves until out_ready rises
    drive(1'b1, 6'd12, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 6'd20, 1'b1, 1'b0);
      tick();
      chk_all($sformatf("stall%0d", c), 1'b0, 1'b1, 36'h000001000, 7'd1, 1'b0);
    end
    drive(1'b1, 6'd20, 1'b1, 1'b1);
    tick();
    chk_all("stall_release", 1'b1, 1'b0, 36'h000001000, 7'd1, 1'b0);
    tick();
    chk_all("stall_pending", 1'b0, 1'b1, 36'h000100000, 7'd1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();

    // reset in the middle of a frame discards it, and no output pulse follows release
    drive(1'b1, 6'd2, 1'b0, 1'b1);
    tick();
    drive(1'b1, 6'd4, 1'b0, 1'b1);
    tick();
    chk_all("mid_accum", 1'b1, 1'b0, 36'h000000014, 7'd2, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("mid_reset", 1'b1, 1'b0, '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_all("mid_released", 1'b1, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 6'd9, 1'b1, 1'b0);
    tick();
    chk_all("post_reset_frame", 1'b0, 1'b1, 36'h000000200, 7'd1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();

    // back-to-back frames with in_valid and out_ready held high
    q = '{2, 4, 6};
    send_frame("b2b_a", q);
    q.delete();
    for (int i = 0; i < VEC_W; i++) q.push_back((i * 7) % VEC_W);
    send_frame("b2b_full", q);
    q = '{10, 10, 50};
    send_frame("b2b_err", q);
    q = '{33, 1};
    send_frame("b2b_clean", q);

    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_code_decoder.md
PRIO_CODE_DECODER -- requirements
Module: prio_code_decoder

Interface
REQ-001 Parameter: VEC_W, default 36, width of the reconstructed decision vector.
REQ-002 Parameter: IDX_W, default 6, width of the index code; 2**IDX_W SHALL be at least VEC_W.
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  an index code is offered.
REQ-006 Port: in_ready  output  1  the block accepts a code this cycle.
REQ-007 Port: in_idx  input  IDX_W  bit position to set in the vector.
REQ-008 Port: in_last  input  1  the accepted code closes the frame.
REQ-009 Port: out_valid  output  1  a completed vector is presented.
REQ-010 Port: out_ready  input  1  the consumer takes the vector.
REQ-011 Port: out_vec  output  VEC_W  reconstructed vector.
REQ-012 Port: out_cnt  output  IDX_W+1  number of distinct bits set in out_vec.
REQ-013 Port: out_err  output  1  the frame contained an out-of-range or duplicate index.

Function
REQ-014 A transfer SHALL occur on any clock edge where in_valid and in_ready are both 1. A code SHALL be counted only on a transfer.
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-016 In IDLE, in_ready SHALL be 1. A transfer SHALL clear the accumulator, apply the code and go to ACCUM. If in_last=1 on that transfer, the FSM SHALL go to HOLD instead.
REQ-017 In ACCUM, in_ready SHALL be 1. Each transfer SHALL set accumulator bit in_idx. A transfer with in_last=1 SHALL move the FSM to HOLD.
REQ-018 In HOLD:
- in_ready SHALL be 0 and out_valid SHALL be 1.
- out_vec, out_cnt and out_err SHALL stay stable until the handshake.
- out_valid and out_ready both 1 SHALL return the FSM to IDLE on that edge.
REQ-019 Latency: out_valid SHALL rise on the first edge after the in_last transfer (one cycle). There SHALL be no combinational path from any input to out_*.
REQ-020 An index at or above VEC_W SHALL set no accumulator bit and SHALL set the sticky frame error.
REQ-021 An index whose accumulator bit is already set SHALL set the sticky frame error, and out_cnt SHALL NOT increment for it.
REQ-022 out_cnt SHALL equal the population count of out_vec. It SHALL be maintained incrementally and SHALL never wrap, since its maximum is VEC_W.
REQ-023 The sticky error SHALL clear only when a new frame starts in IDLE.
REQ-024 in_ready SHALL return to 1 in the cycle after the out handshake. The block SHALL NOT overlap frames (no bypass from HOLD).
REQ-025 An in_valid held high while in HOLD SHALL be ignored. The code SHALL be accepted only once in_ready returns to 1.
REQ-026 out_vec bit i SHALL be 1 iff index i was accepted in the frame, regardless of the order of the codes.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge:
- force the FSM to IDLE;
- set in_ready=1;
- set out_valid=0, out_vec=0, out_cnt=0 and out_err=0.
REQ-028 A partially accumulated frame or an unconsumed HOLD frame SHALL be discarded on reset. No output pulse SHALL follow reset release.
REQ-029 After rst_n deasserts, the first transfer SHALL be accepted on the first rising edge at which in_valid=1.

Verification
REQ-030 Codes 0, 5, 35 with in_last on 35 and out_ready=1 -> the cycle after the last transfer gives out_valid=1, out_vec=bits {0,5,35}, out_cnt=3, out_err=0, then IDLE.
REQ-031 A single code 7 with in_last=1 -> HOLD directly, with out_vec=0x80 and out_cnt=1.
REQ-032 Codes 3, 3, 40(last) -> out_vec=0x8, out_cnt=1, out_err=1. The next frame, code 1(last), gives out_err=0.
REQ-033 out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 throughout and outputs stable. Raising out_ready gives one handshake, and the pending code is accepted the next cycle.
REQ-034 rst_n pulsed low mid-ACCUM after 2 codes -> outputs clear asynchronously. A following frame of code 9(last) gives out_vec=bit 9 only, with out_cnt=1.
REQ-035 Back-to-back frames with constant out_ready=1 and in_valid=1 -> each frame's codes are accepted with exactly one idle (HOLD) cycle between frames, and out_cnt matches popcount every frame.
